// File: rtl/multicycle_sequencer_pkg.sv
// Shared constants for the multicycle sequencer: state encoding, condition codes,
// instruction classes, NZCV bit positions and the compare-opcode range.
package multicycle_sequencer_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned COND_W  = 4;
   localparam int unsigned FLAGS_W = 4;

   typedef logic [STATE_W-1:0] state_t;

   localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] S_FETCH  = 3'd1;
   localparam logic [STATE_W-1:0] S_DECODE = 3'd2;
   localparam logic [STATE_W-1:0] S_EXEC   = 3'd3;
   localparam logic [STATE_W-1:0] S_MEM    = 3'd4;
   localparam logic [STATE_W-1:0] S_WB     = 3'd5;

   localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
   localparam logic [COND_W-1:0] COND_NE = 4'b0001;
   localparam logic [COND_W-1:0] COND_CS = 4'b0010;
   localparam logic [COND_W-1:0] COND_CC = 4'b0011;
   localparam logic [COND_W-1:0] COND_MI = 4'b0100;
   localparam logic [COND_W-1:0] COND_PL = 4'b0101;
   localparam logic [COND_W-1:0] COND_VS = 4'b0110;
   localparam logic [COND_W-1:0] COND_VC = 4'b0111;
   localparam logic [COND_W-1:0] COND_HI = 4'b1000;
   localparam logic [COND_W-1:0] COND_LS = 4'b1001;
   localparam logic [COND_W-1:0] COND_GE = 4'b1010;
   localparam logic [COND_W-1:0] COND_LT = 4'b1011;
   localparam logic [COND_W-1:0] COND_GT = 4'b1100;
   localparam logic [COND_W-1:0] COND_LE = 4'b1101;
   localparam logic [COND_W-1:0] COND_AL = 4'b1110;
   localparam logic [COND_W-1:0] COND_NV = 4'b1111;

   localparam logic [1:0] CLASS_DP  = 2'b00;
   localparam logic [1:0] CLASS_MEM = 2'b01;
   localparam logic [1:0] CLASS_BR  = 2'b10;
   localparam logic [1:0] CLASS_MUL = 2'b11;

   localparam logic [3:0] CMP_OP_LO = 4'b1000;
   localparam logic [3:0] CMP_OP_HI = 4'b1011;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   function automatic logic is_compare(input logic [3:0] op);
      return (op >= CMP_OP_LO) && (op <= CMP_OP_HI);
   endfunction

endpackage

// File: rtl/multicycle_sequencer_cond_check.sv
// Condition-field evaluator: compares a 4-bit condition code against NZCV flags.
module cond_check
   import multicycle_sequencer_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Six-state fetch/decode/execute sequencer with Moore-decoded control outputs.
// Define COND_EXEC_EN to honour the condition field; otherwise every instruction executes.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   output logic        imem_req,
   input  logic        imem_ack,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   input  logic [3:0]  alu_flags,
   output logic [7:0]  alu_ctrl,
   output logic        wen_ARd,
   output logic        reg_file_ctrl_BL,
   output logic        pc_en,
   output logic        pc_sel,
   output logic [3:0]  flags,
   output logic        illegal,
   output logic        busy
);

   state_t      state, state_nx;
   logic [31:0] ir_q;
   logic [3:0]  flags_q;
   logic        store_done_q;

   logic        ir_load, flags_load, store_done_d;
   logic        cond_pass;
   logic [1:0]  iclass;
   logic [3:0]  opcode;
   logic        is_cmp, is_mul_ok, sets_flags;
   logic        unused_ir;

   assign iclass     = ir_q[27:26];
   assign opcode     = ir_q[24:21];
   assign is_cmp     = (iclass == CLASS_DP) && is_compare(opcode);
   assign is_mul_ok  = (iclass == CLASS_MUL) && (ir_q[23:21] == 3'b000);
   assign sets_flags = ((iclass == CLASS_DP) || is_mul_ok) && (ir_q[20] || is_cmp);

`ifdef COND_EXEC_EN
   cond_check u_cond_check (
      .cond  (ir_q[31:28]),
      .flags (flags_q),
      .pass  (cond_pass)
   );
   assign unused_ir = ^ir_q[19:0];
`else
   assign cond_pass = 1'b1;
   assign unused_ir = ^{ir_q[31:28], ir_q[19:0]};
`endif

   assign flags = flags_q;
   assign busy  = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Instruction, architectural flags and the deferred store-completion pc_en pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q         <= 32'h0;
         flags_q      <= 4'h0;
         store_done_q <= 1'b0;
      end else begin
         if (ir_load)    ir_q    <= instr;
         if (flags_load) flags_q <= alu_flags;
         store_done_q <= store_done_d;
      end
   end

   always_comb begin
      state_nx         = state;
      ir_load          = 1'b0;
      flags_load       = 1'b0;
      store_done_d     = 1'b0;
      imem_req         = 1'b0;
      dmem_req         = 1'b0;
      dmem_we          = 1'b0;
      alu_ctrl         = 8'h00;
      wen_ARd          = 1'b0;
      reg_file_ctrl_BL = 1'b0;
      pc_en            = store_done_q;
      pc_sel           = 1'b0;
      illegal          = 1'b0;
      case (state)
         S_IDLE: state_nx = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_load  = 1'b1;
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            if (cond_pass) begin
               state_nx = S_EXEC;
            end else begin
               pc_en    = 1'b1;
               state_nx = S_FETCH;
            end
         end
         S_EXEC: begin
            alu_ctrl   = ir_q[27:20];
            flags_load = sets_flags;
            case (iclass)
               CLASS_DP: begin
                  if (is_cmp) begin
                     pc_en    = 1'b1;
                     state_nx = S_FETCH;
                  end else begin
                     state_nx = S_WB;
                  end
               end
               CLASS_MEM: state_nx = S_MEM;
               CLASS_BR:  state_nx = S_WB;
               default: begin
                  if (is_mul_ok) begin
                     state_nx = S_WB;
                  end else begin
                     illegal  = 1'b1;
                     pc_en    = 1'b1;
                     state_nx = S_FETCH;
                  end
               end
            endcase
         end
         S_MEM: begin
            // Store completion raises pc_en from a register next cycle, keeping ack off the output path.
            alu_ctrl = ir_q[27:20];
            dmem_req = 1'b1;
            dmem_we  = ~ir_q[20];
            if (dmem_ack) begin
               if (ir_q[20]) begin
                  state_nx = S_WB;
               end else begin
                  store_done_d = 1'b1;
                  state_nx     = S_FETCH;
               end
            end
         end
         S_WB: begin
            alu_ctrl = ir_q[27:20];
            wen_ARd  = 1'b1;
            pc_en    = 1'b1;
            if (iclass == CLASS_BR) begin
               pc_sel           = 1'b1;
               reg_file_ctrl_BL = ir_q[24];
            end
            state_nx = S_FETCH;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: the driver pushes hand-computed per-instruction expectations,
// the monitor rebuilds each instruction's footprint from the outputs and compares.
module tb_multicycle_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        imem_req, imem_ack;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [3:0]  alu_flags;
   logic [7:0]  alu_ctrl;
   logic        wen_ARd, reg_file_ctrl_BL, pc_en, pc_sel, illegal, busy;
   logic [3:0]  flags;

   multicycle_sequencer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .instr            (instr),
      .imem_req         (imem_req),
      .imem_ack         (imem_ack),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_ack         (dmem_ack),
      .alu_flags        (alu_flags),
      .alu_ctrl         (alu_ctrl),
      .wen_ARd          (wen_ARd),
      .reg_file_ctrl_BL (reg_file_ctrl_BL),
      .pc_en            (pc_en),
      .pc_sel           (pc_sel),
      .flags            (flags),
      .illegal          (illegal),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [3:0]  af;
      int          lat;   // cycles from the imem_ack cycle to the pc_en cycle
      bit          wen, sel, bl, ill;
      logic [7:0]  alu;   // alu_ctrl two cycles after the ack cycle
      int          dcyc;  // cycles with dmem_req high
      bit          dwe;
      logic [3:0]  flg;   // flags after the instruction retires
   } vec_t;

   vec_t sb[$];
   vec_t vecs[$];
   vec_t e;
   int   tests = 0, failed = 0, done_cnt = 0;
   bit   mon_en = 1'b1;

   bit   act = 0, wait_flags = 0;
   int   lat, pcnt, pc_lat, dcyc;
   bit   wen_s, sel_s, bl_s, ill_s, dwe_s;
   logic [7:0] alu_s;

   function automatic vec_t mk(input string n, input logic [31:0] i, input logic [3:0] af,
                               input int l, input bit w, input bit s, input bit b, input bit il,
                               input logic [7:0] a, input int d, input bit dw, input logic [3:0] f);
      vec_t v;
      v.name = n; v.instr = i; v.af = af; v.lat = l; v.wen = w; v.sel = s; v.bl = b;
      v.ill = il; v.alu = a; v.dcyc = d; v.dwe = dw; v.flg = f;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
      tests++;
      if (act_v !== exp_v) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act_v, exp_v);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      failed++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Monitor: samples on the falling edge, one record per fetched instruction.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!mon_en || !rst_n) begin
            act = 0; wait_flags = 0;
            continue;
         end
         if (wait_flags) begin
            if (pc_en) pcnt++;
            if (sb.size() == 0) begin
               fail_now("scoreboard_empty");
            end else begin
               e = sb.pop_front();
               chk({e.name, "_pc_en_lat"}, 32'(pc_lat), 32'(e.lat));
               chk({e.name, "_pc_en_count"}, 32'(pcnt), 32'd1);
               chk({e.name, "_wen_ARd"}, 32'(wen_s), 32'(e.wen));
               chk({e.name, "_pc_sel"}, 32'(sel_s), 32'(e.sel));
               chk({e.name, "_BL"}, 32'(bl_s), 32'(e.bl));
               chk({e.name, "_illegal"}, 32'(ill_s), 32'(e.ill));
               chk({e.name, "_alu_ctrl"}, 32'(alu_s), 32'(e.alu));
               chk({e.name, "_dmem_cycles"}, 32'(dcyc), 32'(e.dcyc));
               chk({e.name, "_dmem_we"}, 32'(dwe_s), 32'(e.dwe));
               chk({e.name, "_flags"}, 32'(flags), 32'(e.flg));
            end
            act = 0; wait_flags = 0;
            done_cnt++;
         end else if (imem_req && imem_ack) begin
            act = 1; lat = 0; pcnt = 0; pc_lat = -1; dcyc = 0;
            wen_s = 0; sel_s = 0; bl_s = 0; ill_s = 0; dwe_s = 0; alu_s = 8'h00;
         end else if (act) begin
            lat++;
            wen_s |= wen_ARd;
            sel_s |= pc_sel;
            bl_s  |= reg_file_ctrl_BL;
            ill_s |= illegal;
            if (dmem_req) begin
               dcyc++;
               dwe_s |= dmem_we;
            end
            if (lat == 2) alu_s = alu_ctrl;
            if (pc_en) begin
               pcnt++;
               if (pcnt == 1) pc_lat = lat;
               wait_flags = 1;
            end
            if (lat > 60) begin
               fail_now("no_pc_en");
               act = 0;
            end
         end
      end
   end

   // Driver: one instruction per call; acks on the second fetch cycle.
   task automatic run(input vec_t v);
      int cnt, start;
      sb.push_back(v);
      start     = done_cnt;
      alu_flags = v.af;
      cnt = 0;
      for (int i = 0; i < 200 && cnt < 2; i++) begin
         @(posedge clk); #1;
         if (imem_req) cnt++;
      end
      if (cnt < 2) begin
         fail_now({v.name, "_fetch_wait"});
         void'(sb.pop_back());
         return;
      end
      instr    = v.instr;
      imem_ack = 1'b1;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      if (v.dcyc != 0) begin
         cnt = 0;
         for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (dmem_req) cnt++;
            if (cnt == v.dcyc) break;
         end
         if (cnt != v.dcyc) fail_now({v.name, "_dmem_wait"});
         else begin
            dmem_ack = 1'b1;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
         end
      end else begin
         // Stray acks while not fetching / not in MEM must have no effect.
         instr    = 32'hFFFF_FFFF;
         imem_ack = 1'b1;
         dmem_ack = 1'b1;
         @(posedge clk); #1;
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
      end
      for (int i = 0; i < 200 && done_cnt == start; i++) @(posedge clk);
      if (done_cnt == start) begin
         fail_now({v.name, "_retire_wait"});
         if (sb.size() > 0) void'(sb.pop_back());
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int cnt;
      rst_n = 1'b0; instr = 32'h0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_flags = 4'h0;

      vecs.push_back(mk("cmp",      32'hE1510002, 4'b0110, 2, 0, 0, 0, 0, 8'h15, 0, 0, 4'b0110));
      vecs.push_back(mk("adds",     32'hE0921003, 4'b0100, 3, 1, 0, 0, 0, 8'h09, 0, 0, 4'b0100));
      vecs.push_back(mk("bleq_z1",  32'h0B000004, 4'b0000, 3, 1, 1, 1, 0, 8'hB0, 0, 0, 4'b0100));
      vecs.push_back(mk("beq_z1",   32'h0A000004, 4'b0000, 3, 1, 1, 0, 0, 8'hA0, 0, 0, 4'b0100));
      vecs.push_back(mk("add_nos",  32'hE0821003, 4'b1011, 3, 1, 0, 0, 0, 8'h08, 0, 0, 4'b0100));
      vecs.push_back(mk("cmp_clr",  32'hE1510002, 4'b0000, 2, 0, 0, 0, 0, 8'h15, 0, 0, 4'b0000));
`ifdef COND_EXEC_EN
      vecs.push_back(mk("beq_z0",   32'h0A000004, 4'b1111, 1, 0, 0, 0, 0, 8'h00, 0, 0, 4'b0000));
`else
      vecs.push_back(mk("beq_z0",   32'h0A000004, 4'b1111, 3, 1, 1, 0, 0, 8'hA0, 0, 0, 4'b0000));
`endif
      vecs.push_back(mk("ldr",      32'hE5912000, 4'b1111, 6, 1, 0, 0, 0, 8'h59, 3, 0, 4'b0000));
      vecs.push_back(mk("str",      32'hE5812000, 4'b1111, 6, 0, 0, 0, 0, 8'h58, 3, 1, 4'b0000));
      // Bits [27:26]=11 and [23:21]=111: a reserved multiply-class encoding.
      vecs.push_back(mk("illegal",  32'hECE00000, 4'b1111, 2, 0, 0, 0, 1, 8'hCE, 0, 0, 4'b0000));
      vecs.push_back(mk("mul_s",    32'hEC100000, 4'b1001, 3, 1, 0, 0, 0, 8'hC1, 0, 0, 4'b1001));
`ifdef COND_EXEC_EN
      vecs.push_back(mk("never",    32'hF0921003, 4'b0010, 1, 0, 0, 0, 0, 8'h00, 0, 0, 4'b1001));
`else
      vecs.push_back(mk("never",    32'hF0921003, 4'b0010, 3, 1, 0, 0, 0, 8'h09, 0, 0, 4'b0010));
`endif
      vecs.push_back(mk("adds_pre", 32'hE0921003, 4'b0100, 3, 1, 0, 0, 0, 8'h09, 0, 0, 4'b0100));

      repeat (3) @(posedge clk);
      #1;
      chk("reset_imem_req", 32'(imem_req), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_pc_en", 32'(pc_en), 32'd0);
      chk("reset_flags", 32'(flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("idle_imem_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      chk("first_fetch_imem_req", 32'(imem_req), 32'd1);

      foreach (vecs[i]) run(vecs[i]);

      // Reset in the middle of a data access.
      mon_en = 1'b0;
      cnt = 0;
      for (int i = 0; i < 50 && !imem_req; i++) begin
         @(posedge clk); #1;
      end
      instr = 32'hE5912000; imem_ack = 1'b1;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      for (int i = 0; i < 50 && !dmem_req; i++) begin
         @(posedge clk); #1;
      end
      chk("mem_dmem_req_before_reset", 32'(dmem_req), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midmem_rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("midmem_rst_flags", 32'(flags), 32'd0);
      chk("midmem_rst_busy", 32'(busy), 32'd0);
      chk("midmem_rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rerelease_idle_imem_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      chk("rerelease_fetch_imem_req", 32'(imem_req), 32'd1);
      chk("rerelease_busy", 32'(busy), 32'd1);
      mon_en = 1'b1;

      run(mk("add_after_rst", 32'hE0821003, 4'b1111, 3, 1, 0, 0, 0, 8'h08, 0, 0, 4'b0000));

      if (sb.size() != 0) fail_now("scoreboard_leftover");
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
